// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the wide/narrow memory arbiter
package mem_arb_pkg;
    typedef enum logic {
        ArbNarrow = 1'b0,
        ArbWide   = 1'b1
    } arb_state_e;
endpackage

// File: rtl/mem_rsp_owner_pipe.sv
// mem_rsp_owner_pipe: tags bank response slots that belong to wide reads
module mem_rsp_owner_pipe #(
    parameter int unsigned MemoryLatency = 1,
    localparam int unsigned CntW = $clog2(MemoryLatency + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tag_i,
    output logic            rsp_wide_o,
    output logic [CntW-1:0] inflight_o
);
    logic [MemoryLatency-1:0] r_tags;
    logic [CntW-1:0]          r_cnt;
    logic [MemoryLatency:0]   w_shift;
    assign w_shift    = {r_tags, tag_i};
    assign rsp_wide_o = r_tags[MemoryLatency-1];
    assign inflight_o = r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tags <= '0;
            r_cnt  <= '0;
        end else begin
            r_tags <= w_shift[MemoryLatency-1:0];
            r_cnt  <= r_cnt + CntW'(tag_i) - CntW'(rsp_wide_o);
        end
    end
    assert property (@(posedge clk_i) disable iff (rst_i) rsp_wide_o |-> r_cnt != '0);
endmodule

// File: rtl/mem_wide_narrow_arbiter.sv
// mem_wide_narrow_arbiter: chooses narrow or wide ownership of the shared banks
module mem_wide_narrow_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NrPorts       = 4,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned MaxWideBurst  = 16,
    parameter int unsigned MaxWideWait   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrPorts-1:0]                   narrow_q_valid_i,
    input  logic                                 wide_q_valid_i,
    input  logic                                 wide_q_write_i,
    output logic                                 sel_wide_o,
    output logic                                 rsp_wide_o,
    output logic [$clog2(MemoryLatency+1)-1:0]   wide_inflight_o,
    output logic                                 idle_o
);
    localparam int unsigned WcW = $clog2(MaxWideWait + 1);
    localparam int unsigned BcW = $clog2(MaxWideBurst + 1);

    if (MemoryLatency < 1) begin : g_bad_latency
        $fatal(1, "MemoryLatency must be at least 1");
    end
    if (MaxWideBurst < 1) begin : g_bad_burst
        $fatal(1, "MaxWideBurst must be at least 1");
    end
    if (MaxWideWait < 1) begin : g_bad_wait
        $fatal(1, "MaxWideWait must be at least 1");
    end

    arb_state_e     r_state;
    logic [WcW-1:0] r_wcnt;
    logic [BcW-1:0] r_bcnt;
    logic           w_accept;
    logic           w_narrow_pend;
    logic           w_wait_done;
    logic           w_burst_done;

    assign w_accept      = (r_state == ArbWide) && wide_q_valid_i;
    assign w_narrow_pend = |narrow_q_valid_i;
    assign w_wait_done   = r_wcnt == WcW'(MaxWideWait - 1);
    // >= keeps the burst bounded even after bcnt saturated with no narrow traffic
    assign w_burst_done  = r_bcnt >= BcW'(MaxWideBurst - 1);
    assign sel_wide_o    = r_state == ArbWide;
    assign idle_o        = (r_state == ArbNarrow) && (wide_inflight_o == '0)
                           && !w_narrow_pend && !wide_q_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ArbNarrow;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
        end else if (r_state == ArbNarrow) begin
            r_bcnt <= '0;
            if (wide_q_valid_i) begin
                r_wcnt <= (r_wcnt == WcW'(MaxWideWait)) ? r_wcnt : r_wcnt + WcW'(1);
                if (!w_narrow_pend || w_wait_done) r_state <= ArbWide;
            end
        end else begin
            r_wcnt <= '0;
            if (w_accept && r_bcnt != BcW'(MaxWideBurst)) r_bcnt <= r_bcnt + BcW'(1);
            if (!wide_q_valid_i || (w_narrow_pend && w_burst_done)) r_state <= ArbNarrow;
        end
    end

    mem_rsp_owner_pipe #(
        .MemoryLatency(MemoryLatency)
    ) u_owner_pipe (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tag_i      (w_accept && !wide_q_write_i),
        .rsp_wide_o (rsp_wide_o),
        .inflight_o (wide_inflight_o)
    );
endmodule

// File: tb/tb_mem_wide_narrow_arbiter.sv
// tb_mem_wide_narrow_arbiter: scenario and randomized checks against a queue-based reference model
module tb_mem_wide_narrow_arbiter;
    localparam int NP    = 4;
    localparam int LAT   = 2;
    localparam int BURST = 16;
    localparam int WAIT  = 8;
    localparam int CW    = $clog2(LAT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] nv = '0;
    logic          wv = 1'b0;
    logic          ww = 1'b0;
    logic          sel, rsp, idle;
    logic [CW-1:0] infl;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_wide = 1'b0;
    int m_wait = 0;
    int m_burst = 0;
    int cyc = 0;
    int rq[$];
    bit e_sel, e_rsp, e_idle;
    int e_infl;

    always #5 clk = ~clk;

    mem_wide_narrow_arbiter #(
        .NrPorts(NP),
        .MemoryLatency(LAT),
        .MaxWideBurst(BURST),
        .MaxWideWait(WAIT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .narrow_q_valid_i(nv),
        .wide_q_valid_i  (wv),
        .wide_q_write_i  (ww),
        .sel_wide_o      (sel),
        .rsp_wide_o      (rsp),
        .wide_inflight_o (infl),
        .idle_o          (idle)
    );

    // Advance one cycle: the model consumes this cycle's inputs at the edge, then new inputs are
    // applied and the expected outputs of the new cycle are computed for sampling at the negedge.
    task automatic tick(input logic r, input logic [NP-1:0] n, input logic v, input logic w);
        bit np;
        @(posedge clk);
        np = |nv;
        if (rst) begin
            m_wide = 1'b0;
            m_wait = 0;
            m_burst = 0;
            rq.delete();
        end else begin
            if (rq.size() > 0 && rq[0] == cyc) void'(rq.pop_front());
            if (m_wide) begin
                if (wv) begin
                    m_burst++;
                    if (!ww) rq.push_back(cyc + LAT);
                end
                if (!wv || (np && m_burst >= BURST)) begin
                    m_wide = 1'b0;
                    m_wait = 0;
                end
            end else if (wv) begin
                m_wait++;
                if (!np || m_wait >= WAIT) begin
                    m_wide = 1'b1;
                    m_burst = 0;
                end
            end
        end
        cyc++;
        #1;
        rst = r;
        nv = n;
        wv = v;
        ww = w;
        @(negedge clk);
        e_sel  = m_wide;
        e_rsp  = rq.size() > 0 && rq[0] == cyc;
        e_infl = rq.size();
        e_idle = !m_wide && rq.size() == 0 && !(|nv) && !wv;
    endtask

    task automatic drain();
        repeat (LAT + 4) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) begin
            tick(1'b1, '1, 1'b1, 1'b0);
            n_checks++;
            if ({sel, rsp, infl, idle} !== {1'b0, 1'b0, CW'(0), 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: sel/rsp/infl/idle=%b/%b/%0d/%b, required 0/0/0/0", sel, rsp, infl, idle);
            end
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_sel: got %b, required 0", sel);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (sel !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_rise: got %b, required 1", sel);
        end
        drain();
        n_checks++;
        if ({sel, rsp, infl, idle} !== {1'b0, 1'b0, CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_drained_idle: sel/rsp/infl/idle=%b/%b/%0d/%b, required 0/0/0/1", sel, rsp, infl, idle);
        end
    endtask

    task automatic test_lone_read();
        int peak = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, '0, c <= 3, 1'b0);
            if (int'(infl) > peak) peak = int'(infl);
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL lone_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
            n_checks++;
            if (rsp !== (c >= 1 + LAT && c <= 3 + LAT)) begin
                n_fail++;
                $display("FAIL lone_rsp c%0d: got %b, required %b", c, rsp, (c >= 1 + LAT && c <= 3 + LAT));
            end
            if (c <= 3) begin
                n_checks++;
                if (sel !== (c >= 1)) begin
                    n_fail++;
                    $display("FAIL lone_sel c%0d: got %b, required %b", c, sel, c >= 1);
                end
            end
        end
        n_checks++;
        if (peak != LAT) begin
            n_fail++;
            $display("FAIL lone_peak_inflight: got %0d, required %0d", peak, LAT);
        end
        drain();
    endtask

    task automatic test_starvation();
        int first = -1;
        for (int c = 0; c < WAIT + 4; c++) begin
            tick(1'b0, NP'(1), 1'b1, 1'b0);
            if (sel === 1'b1 && first < 0) first = c;
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL starve_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
        end
        n_checks++;
        if (first != WAIT) begin
            n_fail++;
            $display("FAIL starve_switch_cycle: got %0d, required %0d", first, WAIT);
        end
        drain();
    endtask

    task automatic test_burst_cap();
        int beats = 0;
        for (int c = 0; c <= BURST + WAIT + 2; c++) begin
            tick(1'b0, (c == 0) ? NP'(0) : NP'(3), 1'b1, 1'b0);
            if (sel === 1'b1 && c <= BURST + WAIT) beats++;
            n_checks++;
            if (sel !== ((c >= 1 && c <= BURST) || c > BURST + WAIT)) begin
                n_fail++;
                $display("FAIL burst_sel c%0d: got %b, required %b", c, sel, (c >= 1 && c <= BURST) || c > BURST + WAIT);
            end
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL burst_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
        end
        n_checks++;
        if (beats != BURST) begin
            n_fail++;
            $display("FAIL burst_beats: got %0d, required %0d", beats, BURST);
        end
        drain();
    endtask

    task automatic test_writes_untagged();
        int pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, '0, c <= 6, c <= 4);
            if (rsp === 1'b1) pulses++;
            n_checks++;
            if (rsp !== (c == 5 + LAT || c == 6 + LAT)) begin
                n_fail++;
                $display("FAIL writes_rsp c%0d: got %b, required %b", c, rsp, (c == 5 + LAT || c == 6 + LAT));
            end
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL writes_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL writes_pulse_count: got %0d, required 2", pulses);
        end
        drain();
    endtask

    task automatic test_tag_survives_switch();
        for (int c = 0; c < BURST + LAT + 5; c++) begin
            tick(1'b0, (c == 0) ? NP'(0) : NP'(4), c <= BURST, 1'b0);
            if (c == BURST + LAT) begin
                n_checks++;
                if ({sel, rsp} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL survive_last_tag: sel/rsp=%b/%b, required 0/1", sel, rsp);
                end
            end
            if (c == BURST + 1 + LAT) begin
                n_checks++;
                if ({rsp, infl} !== {1'b0, CW'(0)}) begin
                    n_fail++;
                    $display("FAIL survive_after_tag: rsp/infl=%b/%0d, required 0/0", rsp, infl);
                end
            end
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL survive_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            tick($urandom_range(0, 63) == 0,
                 ($urandom_range(0, 2) == 0) ? NP'(0) : NP'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);
            n_checks++;
            if ({sel, rsp, infl, idle} !== {e_sel, e_rsp, CW'(e_infl), e_idle}) begin
                n_fail++;
                $display("FAIL random_model c%0d: sel/rsp/infl/idle=%b/%b/%0d/%b, required %b/%b/%0d/%b",
                         c, sel, rsp, infl, idle, e_sel, e_rsp, e_infl, e_idle);
            end
        end
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_lone_read();
        test_starvation();
        test_burst_cap();
        test_writes_untagged();
        test_tag_survives_switch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
